regfile_2r1w_sb: RTL

- Parametrised multi-port register file; successor to the fixed 32x32 read-select logic.
- Two combinational read ports, one synchronous write port, register 0 hardwired to zero.
- Per-register scoreboard (pending-write bits) lets the decode stage detect RAW hazards.
- Sits between decode (issue/read) and writeback in the single-issue datapath.

---
 rtl/regfile_2r1w_sb.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2-read/1-write register file with per-register pending-write scoreboard
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w_sb #(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 32,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_busy,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy_any
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    // Issue is applied after the writeback clear so a new producer keeps the bit set.
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (we && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
        if (we) begin
            sb_d[wr_addr] = 1'b0;
        end
        if (iss_valid && (iss_addr != '0)) begin
            sb_d[iss_addr] = 1'b1;
        end
        regs_d[0] = '0;
        sb_d[0]   = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            sb_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sb_q <= sb_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // A forwarded port sees its producer complete now, unless a new producer issues alongside.
    always_comb begin
        fwd_a   = we && (wr_addr != '0) && (ra_addr == wr_addr);
        fwd_b   = we && (wr_addr != '0) && (rb_addr == wr_addr);
        ra_data = fwd_a ? wr_data : regs_q[ra_addr];
        rb_data = fwd_b ? wr_data : regs_q[rb_addr];
        ra_busy = sb_q[ra_addr];
        rb_busy = sb_q[rb_addr];
        if (fwd_a && !(iss_valid && (iss_addr == ra_addr))) begin
            ra_busy = 1'b0;
        end
        if (fwd_b && !(iss_valid && (iss_addr == rb_addr))) begin
            rb_busy = 1'b0;
        end
    end
`else
    always_comb begin
        ra_data = regs_q[ra_addr];
        rb_data = regs_q[rb_addr];
        ra_busy = sb_q[ra_addr];
        rb_busy = sb_q[rb_addr];
    end
`endif

    assign busy_any = |sb_q;

endmodule
